// File: rtl/shift_pkg.sv
// Shared encodings for the universal burst shift register.
// Op codes, FSM states and the burst-op predicate.
package shift_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only the shift/rotate family may be repeated by the burst engine.
  function automatic logic is_burst_op(
    input logic [2:0] op
  );
    return (op >= OP_SHR) && (op <= OP_ASR);
  endfunction

endpackage

// File: rtl/shift_univ_core.sv
// Combinational next-state for one universal shift step.
// Used for both single steps and every burst step.
module shift_univ_core
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  input  logic         sil,
  input  logic         sir,
  output logic [N-1:0] q_next
);

  always_comb begin
    q_next = q;
    unique case (op)
      OP_HOLD: q_next = q;
      OP_LOAD: q_next = d;
      OP_SHR:  q_next = {sil, q[N-1:1]};
      OP_SHL:  q_next = {q[N-2:0], sir};
      OP_ROR:  q_next = {q[0], q[N-1:1]};
      OP_ROL:  q_next = {q[N-2:0], q[N-1]};
      OP_ASR:  q_next = {q[N-1], q[N-1:1]};
      OP_CLR:  q_next = '0;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_univ_burst_regn.sv
// N-bit universal shift register with an autonomous burst engine.
// Holds q, the latched burst op, the step counter and the FSM.
module shift_univ_burst_regn
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic [N-1:0]  d,
  input  logic          sil,
  input  logic          sir,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [N-1:0]  q,
  output logic          so_r,
  output logic          so_l,
  output logic          busy,
  output logic          done
);

  state_t        r_state;
  logic [N-1:0]  r_q;
  logic [2:0]    r_op;
  logic [CW-1:0] r_rem;

  logic [2:0]    w_op;
  logic [N-1:0]  w_q_next;
  logic          w_burst;

  // During a burst the latched op drives the core, live op is ignored.
  assign w_op    = (r_state == ST_RUN) ? r_op : op;
  assign w_burst = start && is_burst_op(op);

  shift_univ_core #(
    .N(N)
  ) u_core (
    .op    (w_op),
    .q     (r_q),
    .d     (d),
    .sil   (sil),
    .sir   (sir),
    .q_next(w_q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_op    <= OP_HOLD;
      r_rem   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (en) begin
            if (w_burst) begin
              r_op <= op;
              if (cnt == '0) begin
                r_state <= ST_DONE;
              end else begin
                r_q <= w_q_next;
                if (cnt == CW'(1)) begin
                  r_state <= ST_DONE;
                end else begin
                  r_rem   <= cnt - CW'(1);
                  r_state <= ST_RUN;
                end
              end
            end else begin
              r_q <= w_q_next;
            end
          end
        end
        ST_RUN: begin
          if (en) begin
            r_q   <= w_q_next;
            r_rem <= r_rem - CW'(1);
            if (r_rem == CW'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign q    = r_q;
  assign so_r = r_q[0];
  assign so_l = r_q[N-1];
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_univ_burst_regn.sv
// Self-checking bench: vector table, directed burst sequences,
// and random traffic against a step-counting reference model.
module tb_shift_univ_burst_regn;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    op;
  logic [N-1:0]  d;
  logic          sil;
  logic          sir;
  logic          start;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q;
  logic          so_r;
  logic          so_l;
  logic          busy;
  logic          done;

  int checks;
  int failures;

  // reference model state
  int m_q;
  int m_left;
  int m_op;
  bit m_done;

  shift_univ_burst_regn #(
    .N (N),
    .CW(CW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .op   (op),
    .d    (d),
    .sil  (sil),
    .sir  (sir),
    .start(start),
    .cnt  (cnt),
    .q    (q),
    .so_r (so_r),
    .so_l (so_l),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mstep(input int o, input int v, input int dd,
                               input int sl, input int sr);
    int r;
    case (o)
      0: r = v;
      1: r = dd;
      2: r = (v >> 1) + sl * 128;
      3: r = (v * 2) + sr;
      4: r = (v >> 1) + (v % 2) * 128;
      5: r = (v * 2) + (v / 128);
      6: r = (v >> 1) + (v / 128) * 128;
      default: r = 0;
    endcase
    return r % 256;
  endfunction

  task automatic model(input bit r, input bit e, input int o,
                       input int dd, input int sl, input int sr,
                       input bit st, input int c);
    if (r) begin
      m_q = 0; m_left = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      if (e) begin
        m_q = mstep(m_op, m_q, dd, sl, sr);
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end else if (e) begin
      if (st && o >= 2 && o <= 6) begin
        m_op = o;
        if (c == 0) begin
          m_done = 1;
        end else begin
          m_q = mstep(o, m_q, dd, sl, sr);
          m_left = c - 1;
          if (m_left == 0) m_done = 1;
        end
      end else begin
        m_q = mstep(o, m_q, dd, sl, sr);
      end
    end
  endtask

  // One clock: drive, advance model on the edge, compare 1ns later.
  task automatic cyc(input bit r, input bit e, input logic [2:0] o,
                     input logic [7:0] dd, input bit sl, input bit sr,
                     input bit st, input logic [3:0] c);
    rst = r; en = e; op = o; d = dd;
    sil = sl; sir = sr; start = st; cnt = c;
    @(posedge clk);
    model(r, e, int'(o), int'(dd), int'(sl), int'(sr), st, int'(c));
    #1;
    chk("q", int'(q), m_q);
    chk("busy", int'(busy), int'(m_left > 0));
    chk("done", int'(done), int'(m_done));
    chk("so_r", int'(so_r), m_q % 2);
    chk("so_l", int'(so_l), m_q / 128);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
    logic       sil;
    logic       sir;
    logic       en;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[10];

  initial begin
    checks = 0; failures = 0;
    m_q = 0; m_left = 0; m_op = 0; m_done = 0;
    rst = 1; en = 0; op = 0; d = 0;
    sil = 0; sir = 0; start = 0; cnt = 0;

    tbl[0] = '{3'b001, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[1] = '{3'b010, 8'h00, 1'b1, 1'b0, 1'b1, 8'hD2};
    tbl[2] = '{3'b011, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA4};
    tbl[3] = '{3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 8'h49};
    tbl[4] = '{3'b001, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80};
    tbl[5] = '{3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0};
    tbl[6] = '{3'b111, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[7] = '{3'b001, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[8] = '{3'b010, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A};
    tbl[9] = '{3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 8'h2D};

    // reset with arbitrary inputs
    cyc(1, 1, 3'b001, 8'hFF, 1, 1, 1, 4'd7);
    cyc(1, 1, 3'b101, 8'h3C, 1, 1, 1, 4'd3);
    chk("rst_q", int'(q), 0);
    chk("rst_flags", int'({busy, done, so_r, so_l}), 0);

    foreach (tbl[i]) begin
      cyc(0, tbl[i].en, tbl[i].op, tbl[i].d,
          tbl[i].sil, tbl[i].sir, 0, 4'd0);
      chk($sformatf("vec%0d", i), int'(q), int'(tbl[i].exp_q));
    end

    // ROR burst of 3, start during busy ignored
    cyc(0, 1, 3'b001, 8'h81, 0, 0, 0, 4'd0);
    cyc(0, 1, 3'b100, 8'h00, 0, 0, 1, 4'd3);
    chk("ror1", int'({q, busy, done}), int'({8'hC0, 2'b10}));
    cyc(0, 1, 3'b001, 8'hEE, 1, 1, 1, 4'd9);
    chk("ror2", int'({q, busy, done}), int'({8'h60, 2'b10}));
    cyc(0, 1, 3'b000, 8'h00, 0, 0, 1, 4'd2);
    chk("ror3", int'({q, busy, done}), int'({8'h30, 2'b01}));
    cyc(0, 1, 3'b100, 8'h00, 0, 0, 1, 4'd4);
    chk("ror_end", int'({q, busy, done}), int'({8'h30, 2'b00}));

    // ASR burst of 4 with a 2-cycle stall
    cyc(0, 1, 3'b001, 8'h90, 0, 0, 0, 4'd0);
    cyc(0, 1, 3'b110, 8'h00, 0, 0, 1, 4'd4);
    chk("asr1", int'(q), 8'hC8);
    cyc(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0);
    chk("asr2", int'(q), 8'hE4);
    cyc(0, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0);
    cyc(0, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0);
    chk("asr_stall", int'({q, busy, done}), int'({8'hE4, 2'b10}));
    cyc(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0);
    chk("asr3", int'({q, busy, done}), int'({8'hF2, 2'b10}));
    cyc(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0);
    chk("asr4", int'({q, busy, done}), int'({8'hF9, 2'b01}));
    cyc(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0);

    // cnt=0 burst: done only
    cyc(0, 1, 3'b001, 8'h3C, 0, 0, 0, 4'd0);
    cyc(0, 1, 3'b010, 8'h00, 1, 1, 1, 4'd0);
    chk("cnt0", int'({q, busy, done}), int'({8'h3C, 2'b01}));
    cyc(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0);

    // start with LOAD is a single load
    cyc(0, 1, 3'b001, 8'h77, 0, 0, 1, 4'd5);
    chk("start_load", int'({q, busy, done}), int'({8'h77, 2'b00}));
    cyc(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0);
    chk("start_load2", int'({busy, done}), 0);

    // ROL by 15 on 8 bits equals ROL by 7
    cyc(0, 1, 3'b001, 8'h96, 0, 0, 0, 4'd0);
    cyc(0, 1, 3'b101, 8'h00, 0, 0, 1, 4'd15);
    for (int k = 0; k < 14; k++)
      cyc(0, 1, 3'b000, 8'h00, 1, 1, 0, 4'd0);
    chk("rol15", int'({q, busy, done}), int'({8'h4B, 2'b01}));
    cyc(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0);

    // abort an SHR burst of 8 with reset
    cyc(0, 1, 3'b001, 8'hFF, 0, 0, 0, 4'd0);
    cyc(0, 1, 3'b010, 8'h00, 0, 0, 1, 4'd8);
    chk("abort1", int'(q), 8'h7F);
    cyc(1, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0);
    chk("abort_rst", int'({q, busy, done}), 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0);
      chk("abort_nodone", int'(done), 0);
    end
    cyc(0, 1, 3'b010, 8'h00, 1, 0, 1, 4'd2);
    cyc(0, 1, 3'b000, 8'h00, 1, 0, 0, 4'd0);
    chk("fresh", int'({q, busy, done}), int'({8'hC0, 2'b01}));

    // random traffic
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 4) != 0),
          3'($urandom_range(0, 7)),
          8'($urandom),
          1'($urandom),
          1'($urandom),
          ($urandom_range(0, 3) == 0),
          4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_univ_burst_regn.md
Name: shift_univ_burst_regn

Overview:
- Parametrised N-bit universal shift register and the successor to the 4-bit right-shift register.
- Adds bidirectional shift, rotate, arithmetic shift, load and clear, plus a burst engine.
- The burst engine performs a programmed number of shift/rotate steps autonomously and reports busy/done.
- Sits in datapaths needing serial/parallel conversion, multi-bit shifts without a barrel shifter, or bit-serial protocols.

Parameters:
- N, 8, register width in bits (N >= 2).
- CW, 4, width of the burst count input; counts 0..2^CW-1 are all legal, including counts greater than N.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  clock enable; 0 freezes q and the burst counter.
- op  input  3  operation select (encoding below).
- d  input  N  parallel load data.
- sil  input  1  serial in, enters at MSB on right shift.
- sir  input  1  serial in, enters at LSB on left shift.
- start  input  1  begin burst (shift/rotate ops only).
- cnt  input  CW  burst step count.
- q  output  N  register contents.
- so_r  output  1  q[0], combinational from q.
- so_l  output  1  q[N-1], combinational from q.
- busy  output  1  burst in progress.
- done  output  1  one-cycle burst-complete pulse.

Behaviour:
- Reset is synchronous, active-high, and has priority over everything:
  - q = 0, state IDLE, busy = 0, done = 0, remaining = 0.
- Op encoding:
  - 000 HOLD
  - 001 LOAD (q <= d)
  - 010 SHR (q <= {sil, q[N-1:1]})
  - 011 SHL (q <= {q[N-2:0], sir})
  - 100 ROR
  - 101 ROL
  - 110 ASR (MSB replicated)
  - 111 CLR (q <= 0)
- IDLE, single-step: when en=1 and start=0, op executes once per edge. When en=0, q holds.
- IDLE, burst start: requires en=1, start=1, and op in 010..110.
  - Latch op into op_r.
  - cnt=0: q unchanged, go to DONE.
  - cnt=1: execute first step on this edge, go to DONE.
  - cnt>1: execute first step on this edge, remaining <= cnt-1, go to RUN.
- start with op in {000, 001, 111} is a plain single step; no burst is started.
- RUN:
  - busy=1.
  - Each edge with en=1 executes op_r using live sil/sir and decrements remaining.
  - When remaining reaches 0, go to DONE.
  - en=0 stalls: q and remaining hold, busy stays 1.
  - op, d, start and cnt are ignored.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE unconditionally, independent of en.
  - Inputs are ignored in DONE; a new start is accepted only in IDLE.
- Latency: a burst of K>0 steps with no stalls completes its last step K-1 edges after the start edge. done is high in the cycle after the last step.
- busy and done are registered (decoded from state); never both high.
- rst during RUN or DONE aborts: q=0, no done pulse.
- Serial inputs are sampled every step, so a burst of N SHR steps shifts in N fresh sil bits (serial-to-parallel). so_r presents the bit shifted out (parallel-to-serial).

Decomposition:
- Package shift_pkg holds:
  - op encodings as localparams (OP_HOLD..OP_CLR).
  - FSM state encoding (ST_IDLE, ST_RUN, ST_DONE).
  - an is_burst_op(op) function.
- One natural sub-module, shift_univ_core: combinational (op, q, sil, sir) -> q_next.
  - Shared by single-step and burst paths.
  - Top level holds q, op_r, remaining and the FSM.

Test Plan:
- Reset: assert rst 2 cycles with arbitrary inputs -> q=0x00, busy=0, done=0, so_r=so_l=0.
- Single steps (N=8): LOAD 0xA5 -> 0xA5; SHR sil=1 -> 0xD2; SHL sir=0 -> 0xA4; ROL -> 0x49; ASR on 0x80 -> 0xC0; CLR -> 0x00; en=0 with SHR -> q unchanged.
- Burst ROR cnt=3 from q=0x81 -> q goes 0xC0 (start edge), 0x60, 0x30; busy high 2 cycles; done pulses once the cycle after q=0x30; start asserted during busy is ignored.
- Burst ASR cnt=4 from 0x90 with en=0 for 2 cycles after the second step -> q 0xC8, 0xE4, hold, hold, 0xF2, 0xF9; done delayed by exactly 2 cycles; busy held through the stall.
- Boundaries:
  - start with cnt=0 -> q unchanged, done pulses next cycle, busy never rises.
  - start with op=LOAD -> single load only, no done.
  - cnt=15 ROL on N=8 -> result equals ROL by 7.
- Abort: rst asserted at step 2 of an SHR cnt=8 burst -> next cycle q=0, busy=0, done never pulses; a fresh burst afterwards completes normally.
